// File: rtl/iir_biquad_mux_antiwindup_pkg.sv
// Shared types and widths for the multiplexed biquad servo filter.
// FSM states plus coefficient/sample/accumulator widths.
package iir_pkg;
  localparam int COEF_W = 35;
  localparam int X_W    = 32;
  localparam int Y_W    = 35;
  localparam int ACC_W  = 70;

  typedef enum logic [3:0] {
    SCAN, LATCH,
    MADD1A, MADD1B, MADD2A, MADD2B,
    MADD3A, MADD3B, MADD4A, MADD4B,
    MADD5A, MADD5B, HOLD
  } state_t;
endpackage

// File: rtl/iir_biquad_mux_antiwindup_if.sv
// Channel bundle of the biquad servo: controls, taps, rails, samples.
// slave = filter side, master = driver of samples/taps (bench/system).
interface iir_biquad_mux_antiwindup_if #(
  parameter int N_CH            = 2,
  parameter int SIGNAL_IN_SIZE  = 16,
  parameter int SIGNAL_OUT_SIZE = 16
);
  import iir_pkg::*;

  logic [N_CH-1:0]                       on_in;
  logic [COEF_W*N_CH-1:0]                a1_in;
  logic [COEF_W*N_CH-1:0]                a2_in;
  logic [COEF_W*N_CH-1:0]                b0_in;
  logic [COEF_W*N_CH-1:0]                b1_in;
  logic [COEF_W*N_CH-1:0]                b2_in;
  logic [2*N_CH-1:0]                     railed_in;
  logic [N_CH-1:0]                       hold_in;
  logic [SIGNAL_IN_SIZE*N_CH-1:0]        signal_in;
  logic [(SIGNAL_OUT_SIZE+2)*N_CH-1:0]   signal_out;
  logic [N_CH-1:0]                       valid_out;

  modport master (
    output on_in, a1_in, a2_in, b0_in, b1_in, b2_in,
    output railed_in, hold_in, signal_in,
    input  signal_out, valid_out
  );

  modport slave (
    input  on_in, a1_in, a2_in, b0_in, b1_in, b2_in,
    input  railed_in, hold_in, signal_in,
    output signal_out, valid_out
  );
endinterface

// File: rtl/iir_biquad_mux_antiwindup_madd.sv
// Shared 35x35 signed multiply plus 70-bit add: p = a*b + c.
// Ports: a, b (35b signed operands), c (70b addend), p (70b result).
module iir_mult_add35
  import iir_pkg::*;
(
  input  logic signed [COEF_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  input  logic signed [ACC_W-1:0]  c,
  output logic signed [ACC_W-1:0]  p
);
  logic signed [ACC_W-1:0] prod;

  assign prod = ACC_W'(a) * ACC_W'(b);
  assign p    = prod + c;
endmodule

// File: rtl/iir_biquad_mux_antiwindup.sv
// N_CH-channel biquad servo sharing one multiply-add, round-robin.
// Ports: clk_in, rst_in (sync, active high), bus (channel bundle).
// Optional IIR_SAT_EN: saturate y2out and stored y2h instead of wrapping.
module iir_biquad_mux_antiwindup
  import iir_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int SIGNAL_IN_SIZE  = 16,
  parameter int SIGNAL_OUT_SIZE = 16,
  parameter int A0_SHIFT        = 26,
  parameter int N_WAIT          = 4
) (
  input logic clk_in,
  input logic rst_in,
  iir_biquad_mux_antiwindup_if.slave bus
);
  localparam int LW = SIGNAL_OUT_SIZE + 2;
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WW = (N_WAIT > 1) ? $clog2(N_WAIT) : 1;

  state_t state;
  logic [PW-1:0] ptr, ptr_nx;
  logic [WW-1:0] wcnt;
  logic last, blk;

  logic signed [COEF_W-1:0] a1_l [N_CH];
  logic signed [COEF_W-1:0] a2_l [N_CH];
  logic signed [COEF_W-1:0] b0_l [N_CH];
  logic signed [COEF_W-1:0] b1_l [N_CH];
  logic signed [COEF_W-1:0] b2_l [N_CH];
  logic signed [SIGNAL_IN_SIZE-1:0] sig_l [N_CH];
  logic signed [SIGNAL_IN_SIZE-1:0] sig_q [N_CH];
  logic signed [LW-1:0] byp [N_CH];
  logic signed [LW-1:0] out_q [N_CH];
  logic [N_CH-1:0] rl, rh, valid_q;

  logic signed [X_W-1:0] x1_h [N_CH];
  logic signed [X_W-1:0] x2_h [N_CH];
  logic signed [Y_W-1:0] y1_h [N_CH];
  logic signed [Y_W-1:0] y2h  [N_CH];

  logic signed [X_W-1:0] x0, x1, x_new;
  logic signed [Y_W-1:0] y0, y1, y2, y2_st;
  logic signed [LW-1:0] y2out;
  logic signed [ACC_W-1:0] accum, m_c, p;
  logic signed [COEF_W-1:0] m_a, m_b;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    assign a1_l[c]  = bus.a1_in[c*COEF_W +: COEF_W];
    assign a2_l[c]  = bus.a2_in[c*COEF_W +: COEF_W];
    assign b0_l[c]  = bus.b0_in[c*COEF_W +: COEF_W];
    assign b1_l[c]  = bus.b1_in[c*COEF_W +: COEF_W];
    assign b2_l[c]  = bus.b2_in[c*COEF_W +: COEF_W];
    assign sig_l[c] = bus.signal_in[c*SIGNAL_IN_SIZE +: SIGNAL_IN_SIZE];
    assign rl[c]    = bus.railed_in[2*c];
    assign rh[c]    = bus.railed_in[2*c+1];
    if (SIGNAL_OUT_SIZE >= SIGNAL_IN_SIZE) begin : g_up
      assign byp[c] = LW'(sig_q[c]) <<< (SIGNAL_OUT_SIZE - SIGNAL_IN_SIZE);
    end else begin : g_dn
      assign byp[c] = LW'(sig_q[c] >>> (SIGNAL_IN_SIZE - SIGNAL_OUT_SIZE));
    end
  end

  always_comb begin
    bus.signal_out = '0;
    for (int c = 0; c < N_CH; c++) bus.signal_out[c*LW +: LW] = out_q[c];
  end
  assign bus.valid_out = valid_q;

  iir_mult_add35 u_madd (.a(m_a), .b(m_b), .c(m_c), .p(p));

  assign last   = (wcnt == WW'(N_WAIT - 1));
  assign ptr_nx = (ptr == PW'(N_CH - 1)) ? '0 : ptr + PW'(1);
  assign x_new  = X_W'(sig_l[ptr]) <<< (X_W - SIGNAL_IN_SIZE);

  always_comb begin
    y2    = Y_W'(accum >>> A0_SHIFT);
    y2out = y2[Y_W-2 -: LW];
    y2_st = y2;
`ifdef IIR_SAT_EN
    if (y2[Y_W-1] != y2[Y_W-2]) begin
      y2out = y2[Y_W-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
      y2_st = Y_W'(y2out) <<< (X_W - SIGNAL_OUT_SIZE);
    end
`endif
  end

  // Writeback veto: hold, or moving further into an active rail.
  assign blk = bus.hold_in[ptr]
             | (rl[ptr] && (y2out < out_q[ptr]))
             | (rh[ptr] && (y2out > out_q[ptr]));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= SCAN;
      ptr     <= '0;
      wcnt    <= '0;
      x0      <= '0;
      x1      <= '0;
      y0      <= '0;
      y1      <= '0;
      accum   <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_c     <= '0;
      valid_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        x1_h[c] <= '0;
        x2_h[c] <= '0;
        y1_h[c] <= '0;
        y2h[c]  <= '0;
      end
    end else begin
      valid_q <= '0;
      unique case (state)
        SCAN: begin
          if (bus.on_in[ptr]) begin
            state <= LATCH;
          end else begin
            x1_h[ptr] <= '0;
            x2_h[ptr] <= '0;
            y1_h[ptr] <= '0;
            y2h[ptr]  <= '0;
            ptr       <= ptr_nx;
          end
        end
        LATCH: begin
          x0        <= x1_h[ptr];
          x1        <= x2_h[ptr];
          y0        <= y1_h[ptr];
          y1        <= y2h[ptr];
          x1_h[ptr] <= x2_h[ptr];
          y1_h[ptr] <= y2h[ptr];
          state     <= MADD1A;
        end
        MADD1A: begin
          m_a <= a2_l[ptr]; m_b <= y0; m_c <= '0;
          state <= MADD1B;
        end
        MADD1B: if (last) begin accum <= p; state <= MADD2A; end
        MADD2A: begin
          m_a <= a1_l[ptr]; m_b <= y1; m_c <= accum;
          state <= MADD2B;
        end
        MADD2B: if (last) begin accum <= p; state <= MADD3A; end
        MADD3A: begin
          m_a <= b2_l[ptr]; m_b <= COEF_W'(x0); m_c <= accum;
          state <= MADD3B;
        end
        MADD3B: if (last) begin accum <= p; state <= MADD4A; end
        MADD4A: begin
          m_a <= b1_l[ptr]; m_b <= COEF_W'(x1); m_c <= accum;
          state <= MADD4B;
        end
        // Late capture of the new sample keeps input latency minimal.
        MADD4B: if (last) begin
          accum     <= p;
          x2_h[ptr] <= x_new;
          state     <= MADD5A;
        end
        MADD5A: begin
          m_a <= b0_l[ptr]; m_b <= COEF_W'(x2_h[ptr]); m_c <= accum;
          state <= MADD5B;
        end
        MADD5B: if (last) begin accum <= p; state <= HOLD; end
        HOLD: begin
          if (bus.on_in[ptr]) begin
            valid_q[ptr] <= 1'b1;
            if (!blk) y2h[ptr] <= y2_st;
          end
          ptr   <= ptr_nx;
          state <= SCAN;
        end
        default: state <= SCAN;
      endcase
      if (state inside {MADD1B, MADD2B, MADD3B, MADD4B, MADD5B})
        wcnt <= last ? '0 : wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < N_CH; c++) begin
        sig_q[c] <= '0;
        out_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        sig_q[c] <= sig_l[c];
        out_q[c] <= bus.on_in[c] ? y2h[c][Y_W-2 -: LW] : byp[c];
      end
    end
  end
endmodule
